// File: rtl/rr_handshake_merge.sv
// Round-robin merge of NUM_IN req/ack producer channels into one req/ack
// output stream. The block grants one producer at a time, captures its word,
// hands it downstream tagged with the source channel index, then moves the
// grant to the next channel. A producer that stays silent for TIMEOUT cycles
// is skipped (TIMEOUT = 0 waits forever).
module rr_handshake_merge #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [NUM_IN-1:0]            in_req,
  input  logic [NUM_IN-1:0]            in_ack,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         out_req,
  output logic                         out_ack,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic [31:0]                  out_count
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

  state_t                  state, state_d;
  logic [ID_WIDTH-1:0]     ptr, ptr_d, ptr_inc;
  logic [WAIT_W-1:0]       wait_cnt, wait_d;
  logic [DATA_WIDTH-1:0]   cap_data, cap_data_d;
  logic [NUM_IN-1:0]       in_req_d;
  logic                    out_ack_d;
  logic [DATA_WIDTH-1:0]   out_data_d;
  logic [ID_WIDTH-1:0]     out_id_d;
  logic [31:0]             out_count_d;
  logic                    ack_sel;
  logic [DATA_WIDTH-1:0]   data_sel;

  // Only the granted channel's ack and data slice are ever looked at.
  assign ack_sel  = in_ack[ptr];
  assign data_sel = in_data[int'(ptr) * DATA_WIDTH +: DATA_WIDTH];
  assign ptr_inc  = (int'(ptr) == NUM_IN - 1) ? '0 : ptr + 1'b1;

  // Next-state and registered-output decode; in_req is registered so each
  // producer sees a glitch-free level.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    wait_d      = wait_cnt;
    cap_data_d  = cap_data;
    in_req_d    = in_req;
    out_ack_d   = 1'b0;
    out_data_d  = out_data;
    out_id_d    = out_id;
    out_count_d = out_count;
    case (state)
      IDLE: begin
        state_d       = REQ;
        wait_d        = '0;
        in_req_d      = '0;
        in_req_d[ptr] = 1'b1;
      end
      REQ: begin
        if (ack_sel) begin
          cap_data_d = data_sel;
          in_req_d   = '0;
          state_d    = HOLD;
        end else if (TIMEOUT != 0 && int'(wait_cnt) == TIMEOUT - 1) begin
          in_req_d = '0;
          state_d  = DRAIN;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // A producer may have committed to an ack just as in_req fell.
        in_req_d = '0;
        if (ack_sel) begin
          cap_data_d = data_sel;
          state_d    = HOLD;
        end else begin
          ptr_d             = ptr_inc;
          wait_d            = '0;
          in_req_d[ptr_inc] = 1'b1;
          state_d           = REQ;
        end
      end
      HOLD: begin
        in_req_d = '0;
        if (out_req && !out_ack) begin
          out_ack_d         = 1'b1;
          out_data_d        = cap_data;
          out_id_d          = ptr;
          out_count_d       = out_count + 32'd1;
          ptr_d             = ptr_inc;
          wait_d            = '0;
          in_req_d[ptr_inc] = 1'b1;
          state_d           = REQ;
        end
      end
      default: begin
        in_req_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, pointer, capture and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      wait_cnt  <= '0;
      cap_data  <= '0;
      in_req    <= '0;
      out_ack   <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_count <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      wait_cnt  <= wait_d;
      cap_data  <= cap_data_d;
      in_req    <= in_req_d;
      out_ack   <= out_ack_d;
      out_data  <= out_data_d;
      out_id    <= out_id_d;
      out_count <= out_count_d;
    end
  end

endmodule

// File: tb/tb_rr_handshake_merge.sv
// Bench for rr_handshake_merge: behavioural producers on every channel, a
// round-robin delivery model over the responsive channels, and directed
// scenarios for back-pressure, async reset and the no-timeout variant.
`timescale 1ns/1ps
module tb_rr_handshake_merge;
  localparam int NI = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NI-1:0]    in_req, in_ack;
  logic [NI*DW-1:0] in_data;
  logic             out_req, out_ack;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_id;
  logic [31:0]      out_count;

  logic [NI-1:0]    b_in_req, b_in_ack;
  logic [NI*DW-1:0] b_in_data;
  logic             b_out_req, b_out_ack;
  logic [DW-1:0]    b_out_data;
  logic [IW-1:0]    b_out_id;
  logic [31:0]      b_out_count;

  rr_handshake_merge #(.NUM_IN(NI), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data), .out_id(out_id),
    .out_count(out_count));

  rr_handshake_merge #(.NUM_IN(NI), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .in_req(b_in_req), .in_ack(b_in_ack), .in_data(b_in_data),
    .out_req(b_out_req), .out_ack(b_out_ack), .out_data(b_out_data), .out_id(b_out_id),
    .out_count(b_out_count));

  int tests = 0;
  int fails = 0;

  // producer behaviour: 0 = silent, 1 = acks within the timeout, 2 = acks in the drain cycle
  int mode[NI];
  int seen[NI];
  int dly[NI];
  int word_n[NI];
  int exp_n[NI];
  int maxd;
  int oreq_mode;
  int exp_last;
  logic [31:0] exp_count;

  logic [IW-1:0] got_id[$];
  logic [DW-1:0] got_data[$];
  logic [31:0]   got_cnt[$];
  int rise_ch[$];
  int rise_cyc[$];
  int viol;
  int cyc;
  bit stab_ok;
  logic [NI-1:0] prev_req;
  logic          prev_ack;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;

  function automatic logic [DW-1:0] word(int g, int n);
    return (DW'(g) << 28) | DW'(n);
  endfunction

  // next channel, in round-robin order after 'last', whose producer will answer
  function automatic int next_resp(int last);
    for (int k = 1; k <= NI; k++) begin
      if (mode[(last + k) % NI] != 0) return (last + k) % NI;
    end
    return -1;
  endfunction

  task automatic bench_clear();
    in_ack = '0; b_in_ack = '0; b_in_data = '0; b_out_req = 1'b0;
    for (int g = 0; g < NI; g++) begin
      word_n[g] = 0; exp_n[g] = 0; seen[g] = 0;
      dly[g] = $urandom_range(maxd, 0);
      in_data[g*DW +: DW] = word(g, 0);
    end
    exp_last = NI - 1; exp_count = '0;
    got_id.delete(); got_data.delete(); got_cnt.delete();
    rise_ch.delete(); rise_cyc.delete();
    viol = 0; cyc = 0; stab_ok = 0; prev_req = '0; prev_ack = 1'b0;
    out_req = (oreq_mode == 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bench_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock of the A-side environment: record what the DUT shows, then let
  // each producer decide its ack for the coming edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if ($countones(in_req) > 1) viol++;
    if (in_req != '0 && in_req != prev_req)
      for (int g = 0; g < NI; g++)
        if (in_req[g]) begin rise_ch.push_back(g); rise_cyc.push_back(cyc); end
    if (out_ack) begin
      got_id.push_back(out_id); got_data.push_back(out_data); got_cnt.push_back(out_count);
      if (prev_ack) viol++;
    end else if (stab_ok && (out_data !== prev_data || out_id !== prev_id)) begin
      viol++;
    end
    stab_ok = 1; prev_ack = out_ack; prev_data = out_data; prev_id = out_id;
    for (int g = 0; g < NI; g++)
      if (in_ack[g]) begin word_n[g]++; in_data[g*DW +: DW] = word(g, word_n[g]); end
    in_ack = '0;
    for (int g = 0; g < NI; g++) begin
      if (mode[g] == 1 && in_req[g]) begin
        if (seen[g] >= dly[g]) begin
          in_ack[g] = 1'b1; seen[g] = 0; dly[g] = $urandom_range(maxd, 0);
        end else seen[g]++;
      end else if (mode[g] == 2 && !in_req[g] && prev_req[g]) begin
        in_ack[g] = 1'b1;
      end
    end
    prev_req = in_req;
    out_req = (oreq_mode == 2) ? ($urandom_range(2, 0) != 0) : (oreq_mode == 1);
  endtask

  task automatic test_reset();
    for (int g = 0; g < NI; g++) mode[g] = 0;
    maxd = 0; oreq_mode = 1;
    rst = 1'b0;
    bench_clear();
    @(negedge clk);
    tests++; if (in_req !== '0) begin fails++; $display("FAIL reset_in_req: got %b expected 0", in_req); end
    tests++; if (out_ack !== 1'b0) begin fails++; $display("FAIL reset_out_ack: got %b expected 0", out_ack); end
    tests++; if (out_data !== '0 || out_id !== '0) begin fails++; $display("FAIL reset_out_word: got %h/%0d expected 0/0", out_data, out_id); end
    tests++; if (out_count !== '0) begin fails++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (in_req !== 4'b0001) begin fails++; $display("FAIL first_grant: got %b expected 0001", in_req); end
    tests++; if (b_in_req !== 4'b0001) begin fails++; $display("FAIL first_grant_t0: got %b expected 0001", b_in_req); end
  endtask

  task automatic test_all_ready();
    int g, bad_seq, bad_gap;
    for (int k = 0; k < NI; k++) mode[k] = 1;
    maxd = 0; oreq_mode = 1;
    do_reset();
    for (int i = 0; i < 1000 && got_id.size() < 100; i++) step();
    tests++; if (got_id.size() != 100) begin fails++; $display("FAIL t1_words: got %0d expected 100", got_id.size()); end
    tests++; if (out_count !== 32'd100) begin fails++; $display("FAIL t1_count: got %0d expected 100", out_count); end
    foreach (got_id[i]) begin
      g = next_resp(exp_last); exp_last = g; exp_count++;
      tests++; if (got_id[i] !== IW'(g)) begin fails++; $display("FAIL t1_id[%0d]: got %0d expected %0d", i, got_id[i], g); end
      tests++; if (got_data[i] !== word(g, exp_n[g])) begin fails++; $display("FAIL t1_data[%0d]: got %h expected %h", i, got_data[i], word(g, exp_n[g])); end
      tests++; if (got_cnt[i] !== exp_count) begin fails++; $display("FAIL t1_cnt[%0d]: got %0d expected %0d", i, got_cnt[i], exp_count); end
      exp_n[g]++;
    end
    bad_seq = 0; bad_gap = 0;
    for (int i = 1; i < rise_ch.size(); i++) begin
      if (rise_ch[i] != (rise_ch[i-1] + 1) % NI) bad_seq++;
      if (rise_cyc[i] - rise_cyc[i-1] != 2) bad_gap++;
    end
    tests++; if (bad_seq != 0) begin fails++; $display("FAIL t1_grant_order: got %0d out-of-order grants expected 0", bad_seq); end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL t1_grant_spacing: got %0d gaps not 2 expected 0", bad_gap); end
    tests++; if (viol != 0) begin fails++; $display("FAIL t1_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_timeout_skip();
    int g, bad_seq, bad_gap;
    mode[0] = 0; mode[1] = 0; mode[2] = 1; mode[3] = 0;
    maxd = TO - 1; oreq_mode = 1;
    do_reset();
    repeat (200) step();
    tests++; if (got_id.size() < 5) begin fails++; $display("FAIL t2_words: got %0d expected >=5", got_id.size()); end
    foreach (got_id[i]) begin
      g = next_resp(exp_last); exp_last = g; exp_count++;
      tests++; if (got_id[i] !== IW'(g)) begin fails++; $display("FAIL t2_id[%0d]: got %0d expected %0d", i, got_id[i], g); end
      tests++; if (got_data[i] !== word(g, exp_n[g])) begin fails++; $display("FAIL t2_data[%0d]: got %h expected %h", i, got_data[i], word(g, exp_n[g])); end
      tests++; if (got_cnt[i] !== exp_count) begin fails++; $display("FAIL t2_cnt[%0d]: got %0d expected %0d", i, got_cnt[i], exp_count); end
      exp_n[g]++;
    end
    bad_seq = 0; bad_gap = 0;
    for (int i = 1; i < rise_ch.size(); i++) begin
      if (rise_ch[i] != (rise_ch[i-1] + 1) % NI) bad_seq++;
      if (mode[rise_ch[i-1]] == 0 && rise_cyc[i] - rise_cyc[i-1] != TO + 1) bad_gap++;
    end
    tests++; if (bad_seq != 0) begin fails++; $display("FAIL t2_grant_order: got %0d out-of-order grants expected 0", bad_seq); end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL t2_skip_time: got %0d skips not %0d cycles expected 0", bad_gap, TO + 1); end
    tests++; if (viol != 0) begin fails++; $display("FAIL t2_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_drain_capture();
    int g, bad_seq, bad_gap;
    mode[0] = 1; mode[1] = 2; mode[2] = 1; mode[3] = 1;
    maxd = TO - 1; oreq_mode = 1;
    do_reset();
    repeat (200) step();
    tests++; if (got_id.size() < 10) begin fails++; $display("FAIL t3_words: got %0d expected >=10", got_id.size()); end
    foreach (got_id[i]) begin
      g = next_resp(exp_last); exp_last = g; exp_count++;
      tests++; if (got_id[i] !== IW'(g)) begin fails++; $display("FAIL t3_id[%0d]: got %0d expected %0d", i, got_id[i], g); end
      tests++; if (got_data[i] !== word(g, exp_n[g])) begin fails++; $display("FAIL t3_data[%0d]: got %h expected %h", i, got_data[i], word(g, exp_n[g])); end
      tests++; if (got_cnt[i] !== exp_count) begin fails++; $display("FAIL t3_cnt[%0d]: got %0d expected %0d", i, got_cnt[i], exp_count); end
      exp_n[g]++;
    end
    bad_seq = 0; bad_gap = 0;
    for (int i = 1; i < rise_ch.size(); i++) begin
      if (rise_ch[i] != (rise_ch[i-1] + 1) % NI) bad_seq++;
      if (mode[rise_ch[i-1]] == 2 && rise_cyc[i] - rise_cyc[i-1] != TO + 2) bad_gap++;
    end
    tests++; if (bad_seq != 0) begin fails++; $display("FAIL t3_grant_order: got %0d out-of-order grants expected 0", bad_seq); end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL t3_drain_time: got %0d drain rounds not %0d cycles expected 0", bad_gap, TO + 2); end
    tests++; if (viol != 0) begin fails++; $display("FAIL t3_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_backpressure();
    int bad;
    mode[0] = 1; mode[1] = 0; mode[2] = 0; mode[3] = 0;
    maxd = 0; oreq_mode = 0;
    do_reset();
    in_data[0 +: DW] = 32'h0000_0055;
    repeat (2) step();
    bad = 0;
    repeat (10) begin
      step();
      if (in_req !== '0 || out_ack !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL t4_hold_quiet: got %0d busy cycles expected 0", bad); end
    mode[0] = 0; oreq_mode = 1; out_req = 1'b1;
    repeat (30) step();
    tests++;
    if (got_id.size() != 1) begin
      fails++; $display("FAIL t4_deliveries: got %0d expected 1", got_id.size());
    end else begin
      tests++; if (got_data[0] !== 32'h55) begin fails++; $display("FAIL t4_data: got %h expected 00000055", got_data[0]); end
      tests++; if (got_id[0] !== 2'd0) begin fails++; $display("FAIL t4_id: got %0d expected 0", got_id[0]); end
      tests++; if (got_cnt[0] !== 32'd1) begin fails++; $display("FAIL t4_count: got %0d expected 1", got_cnt[0]); end
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL t4_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int k = 0; k < NI; k++) mode[k] = 1;
    maxd = 0; oreq_mode = 1;
    do_reset();
    repeat (10) step();
    oreq_mode = 0; out_req = 1'b0;
    repeat (6) step();
    tests++; if (out_count === 32'd0) begin fails++; $display("FAIL t5_pre_count: got 0 expected nonzero"); end
    tests++; if (in_req !== '0) begin fails++; $display("FAIL t5_pre_hold: got %b expected 0000", in_req); end
    #2 rst = 1'b0;
    #1;
    tests++; if (out_count !== '0) begin fails++; $display("FAIL t5_count: got %0d expected 0", out_count); end
    tests++; if (out_data !== '0 || out_id !== '0) begin fails++; $display("FAIL t5_word: got %h/%0d expected 0/0", out_data, out_id); end
    tests++; if (out_ack !== 1'b0 || in_req !== '0) begin fails++; $display("FAIL t5_handshake: got %b/%b expected 0/0000", out_ack, in_req); end
    bench_clear();
    @(negedge clk);
    rst = 1'b1;
    oreq_mode = 1;
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin step(); if (in_req != '0) ok = 1; end
    tests++; if (in_req !== 4'b0001) begin fails++; $display("FAIL t5_first_grant: got %b expected 0001", in_req); end
  endtask

  task automatic test_random();
    int g, bad_seq, any;
    for (int r = 0; r < 3; r++) begin
      any = 0;
      for (int k = 0; k < NI; k++) begin mode[k] = $urandom_range(2, 0); any += mode[k]; end
      if (any == 0) mode[$urandom_range(NI-1, 0)] = 1;
      maxd = TO - 1; oreq_mode = 2;
      do_reset();
      repeat (400) step();
      tests++; if (got_id.size() < 10) begin fails++; $display("FAIL rnd%0d_words: got %0d expected >=10", r, got_id.size()); end
      foreach (got_id[i]) begin
        g = next_resp(exp_last); exp_last = g; exp_count++;
        tests++; if (got_id[i] !== IW'(g)) begin fails++; $display("FAIL rnd%0d_id[%0d]: got %0d expected %0d", r, i, got_id[i], g); end
        tests++; if (got_data[i] !== word(g, exp_n[g])) begin fails++; $display("FAIL rnd%0d_data[%0d]: got %h expected %h", r, i, got_data[i], word(g, exp_n[g])); end
        tests++; if (got_cnt[i] !== exp_count) begin fails++; $display("FAIL rnd%0d_cnt[%0d]: got %0d expected %0d", r, i, got_cnt[i], exp_count); end
        exp_n[g]++;
      end
      bad_seq = 0;
      for (int i = 1; i < rise_ch.size(); i++)
        if (rise_ch[i] != (rise_ch[i-1] + 1) % NI) bad_seq++;
      tests++; if (bad_seq != 0) begin fails++; $display("FAIL rnd%0d_grant_order: got %0d out-of-order grants expected 0", r, bad_seq); end
      tests++; if (viol != 0) begin fails++; $display("FAIL rnd%0d_protocol: got %0d violations expected 0", r, viol); end
    end
  endtask

  task automatic test_no_timeout();
    int bad;
    bit ok;
    for (int k = 0; k < NI; k++) mode[k] = 0;
    maxd = 0; oreq_mode = 0;
    do_reset();
    b_out_req = 1'b1;
    b_in_data[0 +: DW]  = 32'h0000_00A0;
    b_in_data[DW +: DW] = 32'hABCD_0001;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (b_in_req[0]) begin b_in_ack[0] = 1'b1; ok = 1; end
    end
    @(negedge clk);
    b_in_ack = '0;
    tests++; if (!ok) begin fails++; $display("FAIL t6_ch0_grant: got none expected grant within 10 cycles"); end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (b_in_req[1]) ok = 1; else @(negedge clk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL t6_ch1_grant: got %b expected 0010", b_in_req); end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (b_in_req !== 4'b0010 || b_out_ack !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL t6_no_skip: got %0d cycles off ch1 expected 0", bad); end
    b_in_ack[1] = 1'b1;
    @(negedge clk);
    b_in_ack = '0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (b_out_ack) ok = 1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL t6_delivery: got no out_ack expected one within 10 cycles"); end
    tests++; if (b_out_id !== 2'd1) begin fails++; $display("FAIL t6_id: got %0d expected 1", b_out_id); end
    tests++; if (b_out_data !== 32'hABCD_0001) begin fails++; $display("FAIL t6_data: got %h expected abcd0001", b_out_data); end
    tests++; if (b_out_count !== 32'd2) begin fails++; $display("FAIL t6_count: got %0d expected 2", b_out_count); end
    tests++; if (b_in_req !== 4'b0100) begin fails++; $display("FAIL t6_next_grant: got %b expected 0100", b_in_req); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_ack = '0; in_data = '0; out_req = 1'b0;
    b_in_ack = '0; b_in_data = '0; b_out_req = 1'b0;
    rst = 1'b0;
    test_reset();
    test_all_ready();
    test_timeout_skip();
    test_drain_capture();
    test_backpressure();
    test_async_reset();
    test_random();
    test_no_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
